// File: rtl/barrel_shift_pipe_if.sv
// barrel_shift_pipe_if: operand/result handshake bundle for barrel_shift_pipe.
//   in_valid/in_ready/in_data/in_amt/in_mode : producer -> shifter operand channel
//   out_valid/out_ready/out_data             : shifter -> consumer result channel
//   master : the environment side (drives operands, takes results)
//   slave  : the shifter side
interface barrel_shift_pipe_if #(
    parameter int unsigned W  = 8,
    parameter int unsigned AW = $clog2(W)
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [AW-1:0] in_amt;
    logic [1:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: pipelined right barrel shifter, one register stage per
// shift-amount bit, valid/ready on both sides, full throughput.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset, clears all stage registers
//   bus   : barrel_shift_pipe_if.slave (operand in, result out)
// Modes: 00 logical right, 01 arithmetic right, 10 rotate right,
//        11 rotate right, or logical left when BARREL_SHIFT_LEFT_EN is defined.
module barrel_shift_pipe #(
    parameter int unsigned W  = 8,
    parameter int unsigned AW = $clog2(W)
) (
    input  logic                clk,
    input  logic                reset,
    barrel_shift_pipe_if.slave  bus
);
    localparam int unsigned S = AW;

    logic [W-1:0] in_word_c;
    logic [S-1:0] v_c;
    logic [S-1:0] rdy_c;

`ifdef BARREL_SHIFT_LEFT_EN
    // Left shift is done as a right shift on the bit-reversed word.
    function automatic logic [W-1:0] bit_rev(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < int'(W); i++) begin
            r[i] = x[int'(W) - 1 - i];
        end
        return r;
    endfunction

    assign in_word_c = (bus.in_mode == 2'b11) ? bit_rev(bus.in_data) : bus.in_data;
`else
    assign in_word_c = bus.in_data;
`endif

    // Stage k may load when it is empty or everything downstream can move;
    // closed form of rdy[k] = !v[k] || rdy[k+1] with rdy[S] = out_ready.
    for (genvar k = 0; k < int'(S); k++) begin : g_rdy
        assign rdy_c[k] = bus.out_ready || !(&v_c[S-1:k]);
    end

    assign bus.in_ready = rdy_c[0] && !reset;

    for (genvar k = 0; k < int'(S); k++) begin : g_stage
        localparam int unsigned SH = 1 << k;

        logic [W-1:0]  src_d;
        logic [AW-1:0] src_a;
        logic [1:0]    src_m;
        logic          src_v;
        logic [W-1:0]  shf_d;

        logic [W-1:0]  data_q;
        logic [AW-1:0] amt_q;
        logic [1:0]    mode_q;
        logic          valid_q;

        if (k == 0) begin : g_head
            assign src_d = in_word_c;
            assign src_a = bus.in_amt;
            assign src_m = bus.in_mode;
            assign src_v = bus.in_valid;
        end else begin : g_body
            assign src_d = g_stage[k-1].data_q;
            assign src_a = g_stage[k-1].amt_q;
            assign src_m = g_stage[k-1].mode_q;
            assign src_v = g_stage[k-1].valid_q;
        end

        // Conditional shift by 2^k; fill depends on mode.
        always_comb begin
            shf_d = src_d;
            if (src_a[k]) begin
                case (src_m)
                    2'b00:   shf_d = {{SH{1'b0}}, src_d[W-1:SH]};
                    2'b01:   shf_d = {{SH{src_d[W-1]}}, src_d[W-1:SH]};
`ifdef BARREL_SHIFT_LEFT_EN
                    2'b11:   shf_d = {{SH{1'b0}}, src_d[W-1:SH]};
`endif
                    default: shf_d = {src_d[SH-1:0], src_d[W-1:SH]};
                endcase
            end
        end

        // Stage register: loads when downstream can accept, else holds.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_q  <= '0;
                amt_q   <= '0;
                mode_q  <= '0;
                valid_q <= 1'b0;
            end else if (rdy_c[k]) begin
                data_q  <= shf_d;
                amt_q   <= src_a;
                mode_q  <= src_m;
                valid_q <= src_v;
            end
        end

        assign v_c[k] = valid_q;
    end

    assign bus.out_valid = g_stage[S-1].valid_q;

`ifdef BARREL_SHIFT_LEFT_EN
    assign bus.out_data = (g_stage[S-1].mode_q == 2'b11) ? bit_rev(g_stage[S-1].data_q)
                                                         : g_stage[S-1].data_q;
`else
    assign bus.out_data = g_stage[S-1].data_q;
`endif

    // The last stage's amount (and, without left mode, its mode) has no consumer.
    logic unused_tail;
    assign unused_tail = ^{g_stage[S-1].amt_q, g_stage[S-1].mode_q};

endmodule
